display_scan_scheduler: RTL
===========================

// Module: display_scan_scheduler
// PURPOSE
//  Time-shares one 7-segment decoder and segment bus across NDIG multiplexed digits.
//  An internal prescaler paces slot timing; it is sequenced by an IDLE/BLANK/DRIVE FSM.
//  Inserts a blanking gap between digits to prevent ghosting.
//  Sits between the display counter (BCD/hex digits) and the board's anode/segment pins.
// PARAMETERS
//  NDIG          4      number of multiplexed digits (2..8)
//  PRESCALE      50000  Clk cycles per digit slot (>= BLANK_CYCLES+1)
//  BLANK_CYCLES  64     cycles at slot head with all anodes off (>= 1)
//  CNT_W         16     prescaler width; 2**CNT_W > PRESCALE
// PORTS
//  Clk        in   1        system clock, all logic on posedge
//  Rst        in   1        synchronous reset, active-high
//  En         in   1        scan enable; 0 = display dark
//  Digits     in   4*NDIG   hex nibbles; [3:0] = digit 0 (least significant)
//  DpIn       in   NDIG     decimal-point request per digit, active-high
//  AnodeN     out  NDIG     digit select, active-low, registered
//  SegN       out  7        {g,f,e,d,c,b,a}, active-low, registered
//  DpN        out  1        decimal point, active-low, registered
//  ScanTick   out  1        1-cycle pulse at each slot start
//  FrameDone  out  1        1-cycle pulse when last digit slot ends
// BEHAVIOUR
//  - Reset: FSM=IDLE, cnt=0, idx=0, AnodeN=all 1, SegN=7'h7F, DpN=1, ScanTick=0, FrameDone=0.
//  - IDLE: outputs dark. Edge where En=1 is sampled: state<=BLANK, cnt<=0, idx<=0,
//    Digits/DpIn latched into frame regs, ScanTick<=1.
//  - cnt increments every cycle in BLANK/DRIVE; slot = cnt 0..PRESCALE-1.
//  - BLANK: anodes off. When cnt==BLANK_CYCLES-1, state<=DRIVE.
//  - DRIVE: AnodeN[idx]=0 and all other anodes 1; SegN=decode(latched nibble idx);
//    DpN=~DpIn_latched[idx]. When cnt==PRESCALE-1: cnt<=0, state<=BLANK, ScanTick<=1.
//    idx<=idx+1, or wraps to 0 when idx==NDIG-1; on wrap, FrameDone<=1 and
//    Digits/DpIn are re-latched in the same cycle.
//  - Outputs are registered from the FSM state: one cycle of latency after a state or idx change.
//  - Decode covers hex 0-F with standard glyphs. Examples: 0=7'b1000000, 1=7'b1111001,
//    8=7'b0000000, A=7'b0001000, F=7'b0001110.
//  - Digits changes mid-frame are ignored until the next frame latch; no tearing.
//  - En deasserted in any state: next edge FSM=IDLE, cnt=0, idx=0; outputs dark one cycle later.
//    If that edge is also a slot end, no ScanTick or FrameDone pulse is issued.
//  - Rst has priority over En and overrides any state mid-slot.
//  - At most one AnodeN bit is low at any time; never low during BLANK.
// CONFIGURATION
//  LEADZERO_BLANK_EN defined: at each frame latch, compute a mask of leading zero
//    digits, scanning down from idx NDIG-1. A masked digit drives AnodeN all 1 during
//    its DRIVE phase. Digit 0 is never masked. A digit whose DpIn bit is 1 stops
//    the masking. Slot timing is unchanged.
//  Not defined: every digit is displayed, including leading zeros.
// TESTING (NDIG=4, PRESCALE=8, BLANK_CYCLES=2)
//  Reset: Rst=1 for 3 cycles with En=1 -> AnodeN=4'hF, SegN=7'h7F, no pulses.
//  Scan order: En=1, Digits=16'h1234 -> AnodeN sequence 1110,1101,1011,0111;
//    each low for 6 cycles, preceded by 2 dark cycles; SegN shows 4,3,2,1;
//    FrameDone every 32 cycles; ScanTick every 8 cycles.
//  Tearing: change Digits 16'h1234->16'h5678 during digit 1 slot -> digits 2,3 still
//    show 2,1; next frame shows 8,7,6,5.
//  En drop mid-DRIVE -> dark one cycle after En=0 is sampled. Re-enable -> restarts at
//    digit 0 with a BLANK phase.
//  LEADZERO_BLANK_EN, Digits=16'h0050 -> digits 3 and 2 dark, digits 1 and 0 show 5,0.
//    Digits=16'h0000 -> only digit 0 lit, showing 7'b1000000.
//  DpIn=4'b0100 -> DpN=0 only during digit 2 DRIVE. With LEADZERO_BLANK_EN and
//    Digits=16'h0001, digit 2 shows 0 with DP.

Source files
------------

// File: rtl/display_scan_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : display_scan_scheduler                                       |
// | Description : Time-shares one 7-segment decoder and segment bus across     |
// |               NDIG multiplexed digits. A prescaler paces each digit slot;  |
// |               every slot opens with a blanking gap (all anodes off) to     |
// |               suppress ghosting, then drives one digit.                    |
// | Ports       : i_clk        system clock (posedge)                          |
// |               i_rst        synchronous reset, active-high                  |
// |               i_en         scan enable, 0 = display dark                   |
// |               i_digits     hex nibbles, [3:0] = digit 0                    |
// |               i_dp_in      decimal-point request per digit, active-high    |
// |               o_anode_n    digit select, active-low, registered            |
// |               o_seg_n      {g,f,e,d,c,b,a}, active-low, registered         |
// |               o_dp_n       decimal point, active-low, registered           |
// |               o_scan_tick  1-cycle pulse at each slot start                |
// |               o_frame_done 1-cycle pulse when the last digit slot ends     |
// | Options     : LEADZERO_BLANK_EN - blank leading zero digits of each frame  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module display_scan_scheduler #(
   parameter int NDIG         = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 64,
   parameter int CNT_W        = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic [4*NDIG-1:0] i_digits,
   input  logic [NDIG-1:0]   i_dp_in,
   output logic [NDIG-1:0]   o_anode_n,
   output logic [6:0]        o_seg_n,
   output logic              o_dp_n,
   output logic              o_scan_tick,
   output logic              o_frame_done
);

   localparam int c_IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_BLANK = 2'd1;
   localparam logic [1:0] c_ST_DRIVE = 2'd2;

   localparam logic [CNT_W-1:0]   c_CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0]   c_CNT_SLOT_END  = CNT_W'(PRESCALE - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST      = c_IDX_W'(NDIG - 1);

   logic [1:0]          r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [c_IDX_W-1:0]  r_idx;
   logic [4*NDIG-1:0]   r_digits;
   logic [NDIG-1:0]     r_dp;

   logic [1:0]          w_state_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [c_IDX_W-1:0]  w_idx_nxt;
   logic                w_latch;
   logic                w_tick;
   logic                w_fdone;

   logic [NDIG-1:0]     w_anode_n;
   logic [6:0]          w_seg_n;
   logic                w_dp_n;
   logic                w_masked;

   // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}
   function automatic logic [6:0] f_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

`ifdef LEADZERO_BLANK_EN
   logic [NDIG-1:0] r_lz_mask;
   logic [NDIG-1:0] w_lz_mask;
   logic            w_lead;

   // Walk down from the most significant digit; the first nonzero digit or
   // the first digit requesting a decimal point ends the leading-zero run.
   always_comb begin
      w_lz_mask = '0;
      w_lead    = 1'b1;
      for (int i = NDIG - 1; i >= 1; i--) begin
         if (w_lead && (i_digits[4*i +: 4] == 4'h0) && !i_dp_in[i]) begin
            w_lz_mask[i] = 1'b1;
         end else begin
            w_lead = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lz_mask <= '0;
      end else if (w_latch) begin
         r_lz_mask <= w_lz_mask;
      end
   end

   assign w_masked = r_lz_mask[r_idx];
`else
   assign w_masked = 1'b0;
`endif

   // State register, slot counter, frame latch and pulses
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= c_ST_IDLE;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_digits     <= '0;
         r_dp         <= '0;
         o_scan_tick  <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_idx        <= w_idx_nxt;
         o_scan_tick  <= w_tick;
         o_frame_done <= w_fdone;
         if (w_latch) begin
            r_digits <= i_digits;
            r_dp     <= i_dp_in;
         end
      end
   end

   // Next-state logic; a low enable wins over any slot-end event
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_latch     = 1'b0;
      w_tick      = 1'b0;
      w_fdone     = 1'b0;
      if (!i_en) begin
         w_state_nxt = c_ST_IDLE;
         w_cnt_nxt   = '0;
         w_idx_nxt   = '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               w_state_nxt = c_ST_BLANK;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_latch     = 1'b1;
               w_tick      = 1'b1;
            end
            c_ST_BLANK: begin
               w_cnt_nxt = r_cnt + 1'b1;
               if (r_cnt == c_CNT_BLANK_END) begin
                  w_state_nxt = c_ST_DRIVE;
               end
            end
            c_ST_DRIVE: begin
               if (r_cnt == c_CNT_SLOT_END) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = c_ST_BLANK;
                  w_tick      = 1'b1;
                  if (r_idx == c_IDX_LAST) begin
                     w_idx_nxt = '0;
                     w_fdone   = 1'b1;
                     w_latch   = 1'b1;
                  end else begin
                     w_idx_nxt = r_idx + 1'b1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            default: begin
               w_state_nxt = c_ST_IDLE;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end
         endcase
      end
   end

   // Pin values for the current state; segments are also dark whenever no
   // anode is selected so the bus never carries a stale glyph.
   always_comb begin
      w_anode_n = '1;
      w_seg_n   = 7'h7F;
      w_dp_n    = 1'b1;
      if ((r_state == c_ST_DRIVE) && !w_masked) begin
         w_anode_n = ~(NDIG'(1) << r_idx);
         w_seg_n   = f_decode(r_digits[4*r_idx +: 4]);
         w_dp_n    = ~r_dp[r_idx];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_anode_n <= '1;
         o_seg_n   <= 7'h7F;
         o_dp_n    <= 1'b1;
      end else begin
         o_anode_n <= w_anode_n;
         o_seg_n   <= w_seg_n;
         o_dp_n    <= w_dp_n;
      end
   end

endmodule
`default_nettype wire
